mem_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the pipeline's fetch port (I, read-only)
//  and memory-stage port (D, load/store). Grants one access at a time and sequences a

---
 rtl/mips_mem_pkg.sv | 23 ++
 rtl/mem_arb_select.sv | 37 +++
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 501 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// ----------------------------------------------------------------------------
// mips_mem_pkg
// Shared types and constants for the unified-memory arbiter.
//   stateT  : arbiter transaction phase (IDLE -> ACCESS -> RESP)
//   ownerT  : which pipeline port owns the current transaction
//   MEM_LAT_DEFAULT : default number of memory access cycles
// ----------------------------------------------------------------------------
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } stateT;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } ownerT;

    localparam int MEM_LAT_DEFAULT = 2;

endpackage

// File: rtl/mem_arb_select.sv
// ----------------------------------------------------------------------------
// mem_arb_select
// Combinational grant decision between the fetch (I) and data (D) ports.
// Only meaningful when at least one request is high.
//   iReq       in  : fetch port request
//   dReq       in  : data port request
//   lastOwner  in  : port granted most recently
//   grantOwner out : port to grant this cycle
// Parameter RR_EN: 0 = D always wins a tie, 1 = the port not served last wins.
// ----------------------------------------------------------------------------
module mem_arb_select
    import mips_mem_pkg::*;
#(
    parameter int RR_EN = 0
) (
    input  logic  iReq,
    input  logic  dReq,
    input  ownerT lastOwner,
    output ownerT grantOwner
);

    always_comb begin
        // NOTE: assigning a default before any branching guarantees every path
        // drives the output, so no latch is inferred.
        grantOwner = OWN_I;
        if (iReq && dReq) begin
            if (RR_EN != 0) begin
                grantOwner = (lastOwner == OWN_D) ? OWN_I : OWN_D;
            end else begin
                grantOwner = OWN_D;
            end
        end else if (dReq) begin
            grantOwner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-ported unified memory between the fetch port (I, read-only)
// and the memory-stage port (D, load/store). One transaction at a time:
// IDLE (arbitrate + latch) -> ACCESS (MEM_LAT cycles) -> RESP (one-cycle ack).
//   clk, rst                 : clock, synchronous active-high reset
//   i_req/i_addr             : fetch request and address (held until i_ack)
//   i_rdata/i_ack/i_stall    : fetch data, completion pulse, stall to hazard unit
//   d_req/d_we/d_addr/d_wdata: data request, store flag, address, store data
//   d_rdata/d_ack/d_stall    : load data, completion pulse, stall to hazard unit
//   mem_en/mem_we            : access in progress, write strobe (last access cycle)
//   mem_addr/mem_wdata       : latched address and store data
//   mem_rdata                : memory read data, valid in the last access cycle
// ----------------------------------------------------------------------------
module mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = MEM_LAT_DEFAULT,
    parameter int RR_EN   = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ack,
    output logic          i_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          d_stall,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int            CW       = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

    stateT         state;
    stateT         stateNext;
    logic [CW-1:0] cnt;
    ownerT         owner;
    ownerT         lastOwner;
    ownerT         grantOwner;
    logic          weLatched;
    logic          anyReq;
    logic          lastBeat;

    assign anyReq   = i_req | d_req;
    assign lastBeat = (state == ACCESS) && (cnt == CNT_LAST);

    mem_arb_select #(
        .RR_EN(RR_EN)
    ) u_select (
        .iReq      (i_req),
        .dReq      (d_req),
        .lastOwner (lastOwner),
        .grantOwner(grantOwner)
    );

    // Next-state and output decode.
    always_comb begin
        stateNext = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        i_ack     = 1'b0;
        d_ack     = 1'b0;
        unique case (state)
            IDLE: begin
                if (anyReq) stateNext = ACCESS;
            end
            ACCESS: begin
                mem_en = 1'b1;
                // Strobe only in the final beat, so a store aborted by reset
                // earlier never writes.
                mem_we = (owner == OWN_D) && weLatched && (cnt == CNT_LAST);
                if (lastBeat) stateNext = RESP;
            end
            RESP: begin
                i_ack     = (owner == OWN_I);
                d_ack     = (owner == OWN_D);
                // Arbitration happens only in IDLE, so a req still high here is
                // not re-granted.
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign i_stall = i_req & ~i_ack;
    assign d_stall = d_req & ~d_ack;

    // State register, transaction latches and per-port read data.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            // NOTE: the read-data holding registers are reset too, because both
            // rdata outputs must read 0 after reset.
            state     <= IDLE;
            cnt       <= '0;
            owner     <= OWN_I;
            lastOwner <= OWN_I;
            weLatched <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            state <= stateNext;
            unique case (state)
                IDLE: begin
                    if (anyReq) begin
                        owner     <= grantOwner;
                        lastOwner <= grantOwner;
                        cnt       <= '0;
                        if (grantOwner == OWN_D) begin
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            weLatched <= d_we;
                        end else begin
                            mem_addr  <= i_addr;
                            mem_wdata <= '0;
                            weLatched <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (lastBeat) begin
                        // Stores leave d_rdata untouched.
                        if (!weLatched) begin
                            if (owner == OWN_D) d_rdata <= mem_rdata;
                            else                i_rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter. Three instances share the same stimulus:
//   index 0 : MEM_LAT=2, fixed priority
//   index 1 : MEM_LAT=2, round-robin
//   index 2 : MEM_LAT=1, fixed priority
// Cycle n of a scenario is the period after the n-th rising edge counted from
// the moment the scenario first drives its requests (cycle 0).
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        iReq;
    logic [31:0] iAddr;
    logic        dReq;
    logic        dWe;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic [31:0] memRdata;

    logic [31:0] iRdata   [3];
    logic [31:0] dRdata   [3];
    logic [31:0] memAddr  [3];
    logic [31:0] memWdata [3];
    logic        iAck     [3];
    logic        iStall   [3];
    logic        dAck     [3];
    logic        dStall   [3];
    logic        memEn    [3];
    logic        memWe    [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(2), .RR_EN(0)) dutFixed (
        .clk(clk), .rst(rst),
        .i_req(iReq), .i_addr(iAddr), .i_rdata(iRdata[0]), .i_ack(iAck[0]), .i_stall(iStall[0]),
        .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata),
        .d_rdata(dRdata[0]), .d_ack(dAck[0]), .d_stall(dStall[0]),
        .mem_en(memEn[0]), .mem_we(memWe[0]), .mem_addr(memAddr[0]),
        .mem_wdata(memWdata[0]), .mem_rdata(memRdata)
    );

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(2), .RR_EN(1)) dutRr (
        .clk(clk), .rst(rst),
        .i_req(iReq), .i_addr(iAddr), .i_rdata(iRdata[1]), .i_ack(iAck[1]), .i_stall(iStall[1]),
        .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata),
        .d_rdata(dRdata[1]), .d_ack(dAck[1]), .d_stall(dStall[1]),
        .mem_en(memEn[1]), .mem_we(memWe[1]), .mem_addr(memAddr[1]),
        .mem_wdata(memWdata[1]), .mem_rdata(memRdata)
    );

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .RR_EN(0)) dutLat1 (
        .clk(clk), .rst(rst),
        .i_req(iReq), .i_addr(iAddr), .i_rdata(iRdata[2]), .i_ack(iAck[2]), .i_stall(iStall[2]),
        .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata),
        .d_rdata(dRdata[2]), .d_ack(dAck[2]), .d_stall(dStall[2]),
        .mem_en(memEn[2]), .mem_we(memWe[2]), .mem_addr(memAddr[2]),
        .mem_wdata(memWdata[2]), .mem_rdata(memRdata)
    );

    // All outputs of one instance packed together, for "everything is zero" checks.
    function automatic logic [133:0] outs(input int k);
        return {iRdata[k], dRdata[k], memAddr[k], memWdata[k],
                iAck[k], iStall[k], dAck[k], dStall[k], memEn[k], memWe[k]};
    endfunction

    // Advance past the next rising edge; inputs driven afterwards are stable
    // well before the following edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Let combinational outputs follow freshly driven inputs before sampling.
    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        iReq     = 1'b0;
        iAddr    = '0;
        dReq     = 1'b0;
        dWe      = 1'b0;
        dAddr    = '0;
        dWdata   = '0;
        memRdata = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        iReq     = 1'b0;
        dReq     = 1'b0;
        dWe      = 1'b0;
        iAddr    = 32'h1234;
        dAddr    = 32'h5678;
        dWdata   = 32'h9ABC;
        memRdata = 32'hFFFF_FFFF;
        step();
        step();
        settle();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (outs(k) !== '0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got %h expected 0", k, outs(k));
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_fetch_latency();
        logic expEn, expAck, expStall;
        do_reset();
        iReq     = 1'b1;
        iAddr    = 32'h40;
        memRdata = 32'hDEAD_BEEF;
        for (int cyc = 0; cyc <= 4; cyc++) begin
            settle();
            expEn    = (cyc == 1) || (cyc == 2);
            expAck   = (cyc == 3);
            expStall = (cyc <= 2);
            checks++;
            if (memEn[0] !== expEn) begin
                errors++;
                $display("FAIL fetch_mem_en cycle %0d: got %b expected %b", cyc, memEn[0], expEn);
            end
            checks++;
            if (iAck[0] !== expAck) begin
                errors++;
                $display("FAIL fetch_i_ack cycle %0d: got %b expected %b", cyc, iAck[0], expAck);
            end
            checks++;
            if (iStall[0] !== expStall) begin
                errors++;
                $display("FAIL fetch_i_stall cycle %0d: got %b expected %b", cyc, iStall[0], expStall);
            end
            if (cyc == 1) begin
                checks++;
                if (memAddr[0] !== 32'h40) begin
                    errors++;
                    $display("FAIL fetch_mem_addr: got %h expected 00000040", memAddr[0]);
                end
            end
            if (cyc == 3) begin
                checks++;
                if (iRdata[0] !== 32'hDEAD_BEEF) begin
                    errors++;
                    $display("FAIL fetch_i_rdata: got %h expected deadbeef", iRdata[0]);
                end
            end
            step();
            if (cyc == 3) iReq = 1'b0;
        end
    endtask

    task automatic test_fixed_priority();
        int   dAckCyc;
        int   iAckCyc;
        logic dNow, iNow;
        dAckCyc = -1;
        iAckCyc = -1;
        do_reset();
        iReq     = 1'b1;
        iAddr    = 32'h40;
        dReq     = 1'b1;
        dWe      = 1'b0;
        dAddr    = 32'h80;
        memRdata = 32'hCAFE_0001;
        for (int cyc = 0; cyc < 10; cyc++) begin
            settle();
            dNow = dAck[0];
            iNow = iAck[0];
            if (dNow && dAckCyc < 0) dAckCyc = cyc;
            if (iNow && iAckCyc < 0) iAckCyc = cyc;
            if (cyc == 1) begin
                checks++;
                if (memAddr[0] !== 32'h80) begin
                    errors++;
                    $display("FAIL prio_first_addr: got %h expected 00000080", memAddr[0]);
                end
            end
            if (cyc == 3) begin
                checks++;
                if (dRdata[0] !== 32'hCAFE_0001) begin
                    errors++;
                    $display("FAIL prio_d_rdata: got %h expected cafe0001", dRdata[0]);
                end
                checks++;
                if (iRdata[0] !== 32'h0) begin
                    errors++;
                    $display("FAIL prio_unserved_i_rdata: got %h expected 00000000", iRdata[0]);
                end
            end
            if (cyc == 5) begin
                checks++;
                if (memAddr[0] !== 32'h40) begin
                    errors++;
                    $display("FAIL prio_second_addr: got %h expected 00000040", memAddr[0]);
                end
            end
            step();
            if (dNow) dReq = 1'b0;
            if (iNow) iReq = 1'b0;
        end
        checks++;
        if (dAckCyc != 3) begin
            errors++;
            $display("FAIL prio_d_ack_cycle: got %0d expected 3", dAckCyc);
        end
        checks++;
        if (iAckCyc != 7) begin
            errors++;
            $display("FAIL prio_i_ack_cycle: got %0d expected 7", iAckCyc);
        end
    endtask

    task automatic test_store();
        logic done;
        logic ackNow;
        int   weCount;
        int   weCyc;
        int   ackCount;
        do_reset();
        // Preload d_rdata with a known value through a load.
        dReq     = 1'b1;
        dWe      = 1'b0;
        dAddr    = 32'h10;
        memRdata = 32'h5555_AAAA;
        done     = 1'b0;
        for (int k = 0; k < 10; k++) begin
            settle();
            if (dAck[0]) done = 1'b1;
            step();
            if (done) break;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL store_preload_ack: got %b expected 1", done);
        end
        dReq = 1'b0;
        step();

        weCount  = 0;
        weCyc    = -1;
        ackCount = 0;
        dReq     = 1'b1;
        dWe      = 1'b1;
        dAddr    = 32'h100;
        dWdata   = 32'h1234_5678;
        memRdata = 32'hFFFF_FFFF;
        for (int cyc = 0; cyc < 6; cyc++) begin
            settle();
            ackNow = dAck[0];
            if (ackNow) ackCount++;
            if (memWe[0]) begin
                weCount++;
                weCyc = cyc;
                checks++;
                if (memAddr[0] !== 32'h100 || memWdata[0] !== 32'h1234_5678) begin
                    errors++;
                    $display("FAIL store_we_payload: got addr %h data %h expected 00000100 12345678",
                             memAddr[0], memWdata[0]);
                end
            end
            if (cyc == 3) begin
                checks++;
                if (ackNow !== 1'b1) begin
                    errors++;
                    $display("FAIL store_d_ack_cycle3: got %b expected 1", ackNow);
                end
                checks++;
                if (dRdata[0] !== 32'h5555_AAAA) begin
                    errors++;
                    $display("FAIL store_d_rdata_hold: got %h expected 5555aaaa", dRdata[0]);
                end
            end
            step();
            // Disturb the inputs mid-access; the latched values must win.
            if (cyc == 0) begin
                dAddr  = 32'h200;
                dWdata = 32'h0;
                dWe    = 1'b0;
            end
            if (ackNow) dReq = 1'b0;
        end
        checks++;
        if (weCount != 1 || weCyc != 2) begin
            errors++;
            $display("FAIL store_we_once: got count %0d cycle %0d expected 1 at cycle 2", weCount, weCyc);
        end
        checks++;
        if (ackCount != 1) begin
            errors++;
            $display("FAIL store_ack_count: got %0d expected 1", ackCount);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] grants [2][4];
        int          n      [2];
        logic        prevEn [2];
        logic [31:0] expAddr;
        do_reset();
        for (int j = 0; j < 2; j++) begin
            n[j]      = 0;
            prevEn[j] = 1'b0;
            for (int k = 0; k < 4; k++) grants[j][k] = '0;
        end
        iReq     = 1'b1;
        iAddr    = 32'h40;
        dReq     = 1'b1;
        dWe      = 1'b0;
        dAddr    = 32'h80;
        memRdata = 32'h0;
        // Grants land at edges 0, 4, 8, 12; ACCESS starts in cycles 1, 5, 9, 13.
        for (int cyc = 0; cyc < 16; cyc++) begin
            settle();
            for (int j = 0; j < 2; j++) begin
                if (memEn[j] && !prevEn[j]) begin
                    if (n[j] < 4) grants[j][n[j]] = memAddr[j];
                    n[j]++;
                end
                prevEn[j] = memEn[j];
            end
            step();
        end
        iReq = 1'b0;
        dReq = 1'b0;
        for (int j = 0; j < 2; j++) begin
            checks++;
            if (n[j] != 4) begin
                errors++;
                $display("FAIL arb_grant_count[%0d]: got %0d expected 4", j, n[j]);
            end
            for (int k = 0; k < 4; k++) begin
                expAddr = 32'h80;
                if (j == 1 && (k % 2) == 1) expAddr = 32'h40;
                checks++;
                if (grants[j][k] !== expAddr) begin
                    errors++;
                    $display("FAIL arb_grant_order[%0d][%0d]: got %h expected %h",
                             j, k, grants[j][k], expAddr);
                end
            end
        end
    endtask

    task automatic test_reset_mid_store();
        logic weSeen;
        logic ackNow;
        int   ackCyc;
        logic [31:0] ackData;
        weSeen  = 1'b0;
        ackCyc  = -1;
        ackData = '0;
        do_reset();
        dReq   = 1'b1;
        dWe    = 1'b1;
        dAddr  = 32'h100;
        dWdata = 32'hA5A5_A5A5;
        settle();
        weSeen |= memWe[0];
        step();
        // Cycle 1: first access beat; reset asserted now.
        rst  = 1'b1;
        dReq = 1'b0;
        dWe  = 1'b0;
        settle();
        weSeen |= memWe[0];
        checks++;
        if (memEn[0] !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_access: got mem_en %b expected 1", memEn[0]);
        end
        step();
        settle();
        weSeen |= memWe[0];
        checks++;
        if (outs(0) !== '0) begin
            errors++;
            $display("FAIL abort_outputs_zero: got %h expected 0", outs(0));
        end
        step();
        rst = 1'b0;

        iReq     = 1'b1;
        iAddr    = 32'h44;
        memRdata = 32'h0BAD_F00D;
        for (int cyc = 0; cyc < 5; cyc++) begin
            settle();
            weSeen |= memWe[0];
            ackNow = iAck[0];
            if (ackNow && ackCyc < 0) begin
                ackCyc  = cyc;
                ackData = iRdata[0];
            end
            step();
            if (ackNow) iReq = 1'b0;
        end
        checks++;
        if (weSeen !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_mem_we: got %b expected 0", weSeen);
        end
        checks++;
        if (ackCyc != 3 || ackData !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL abort_fresh_fetch: got ack cycle %0d data %h expected 3 0badf00d",
                     ackCyc, ackData);
        end
    endtask

    task automatic test_back_to_back();
        int   ackCycs [3];
        int   n;
        logic prevAck;
        logic twoInRow;
        logic ackNow;
        n        = 0;
        prevAck  = 1'b0;
        twoInRow = 1'b0;
        for (int k = 0; k < 3; k++) ackCycs[k] = -1;
        do_reset();
        dReq     = 1'b1;
        dWe      = 1'b0;
        dAddr    = 32'h20;
        memRdata = 32'h100;
        for (int cyc = 0; cyc < 12; cyc++) begin
            settle();
            ackNow = dAck[2];
            if (ackNow) begin
                if (prevAck) twoInRow = 1'b1;
                if (n < 3) begin
                    ackCycs[n] = cyc;
                    checks++;
                    if (dRdata[2] !== 32'h100 + 32'(n)) begin
                        errors++;
                        $display("FAIL b2b_d_rdata[%0d]: got %h expected %h",
                                 n, dRdata[2], 32'h100 + 32'(n));
                    end
                end
                n++;
            end
            prevAck = ackNow;
            step();
            if (ackNow) begin
                if (n >= 3) begin
                    dReq = 1'b0;
                end else begin
                    dAddr    = dAddr + 32'd4;
                    memRdata = 32'h100 + 32'(n);
                end
            end
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL b2b_ack_count: got %0d expected 3", n);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ackCycs[k] != 2 + 3 * k) begin
                errors++;
                $display("FAIL b2b_ack_cycle[%0d]: got %0d expected %0d", k, ackCycs[k], 2 + 3 * k);
            end
        end
        checks++;
        if (twoInRow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ack_consecutive: got %b expected 0", twoInRow);
        end
    endtask

    initial begin
        test_reset();
        test_fetch_latency();
        test_fixed_priority();
        test_store();
        test_round_robin();
        test_reset_mid_store();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
